// File: rtl/fifo_ctrl_fsm_param.sv
// fifo_ctrl_fsm_param: control FSM for a FIFO subsystem (RESET/INIT/IDLE/ACTIVE/ERROR).
//   - Thresholds are latched while in INIT. They are checked on INIT exit: ae >= af is illegal.
//   - ACTIVE->IDLE is debounced by IDLE_DLY consecutive all-empty cycles.
//   - FIFO error flags are sticky and accumulate while in ERROR.
//   - ERROR is left only on a rising edge of init.
//   - err_count_o counts ERROR entries and saturates at its maximum value.
// Ports:
//   clk, reset (sync, active-high), init (level)
//   fifo_errors/fifo_empties [NUM_FIFOS]      per-FIFO status inputs
//   af_*_i/ae_*_i -> af_*_o/ae_*_o            threshold inputs and their latched copies
//   state_o (one-hot), idle_out, active_out, error_out, cfg_err_o, err_count_o

// Compares one group of threshold channels; fail is set if any channel has ae >= af.
module fifo_th_chk #(
  parameter int N    = 1,
  parameter int TH_W = 2
) (
  input  logic [N*TH_W-1:0] af,
  input  logic [N*TH_W-1:0] ae,
  output logic              fail
);
  logic [N-1:0] ch_fail;
  for (genvar g = 0; g < N; g++) begin : g_ch
    assign ch_fail[g] = ae[g*TH_W +: TH_W] >= af[g*TH_W +: TH_W];
  end
  assign fail = |ch_fail;
endmodule

module fifo_ctrl_fsm_param #(
  parameter int NUM_FIFOS = 5,
  parameter int NUM_MF    = 1,
  parameter int NUM_VC    = 2,
  parameter int NUM_D     = 1,
  parameter int TH_W      = 2,
  parameter int IDLE_DLY  = 4,
  parameter int ERRCNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   init,
  input  logic [NUM_FIFOS-1:0]   fifo_errors,
  input  logic [NUM_FIFOS-1:0]   fifo_empties,
  input  logic [NUM_MF*TH_W-1:0] af_mf_i,
  input  logic [NUM_MF*TH_W-1:0] ae_mf_i,
  input  logic [NUM_VC*TH_W-1:0] af_vc_i,
  input  logic [NUM_VC*TH_W-1:0] ae_vc_i,
  input  logic [NUM_D*TH_W-1:0]  af_d_i,
  input  logic [NUM_D*TH_W-1:0]  ae_d_i,
  output logic [NUM_MF*TH_W-1:0] af_mf_o,
  output logic [NUM_MF*TH_W-1:0] ae_mf_o,
  output logic [NUM_VC*TH_W-1:0] af_vc_o,
  output logic [NUM_VC*TH_W-1:0] ae_vc_o,
  output logic [NUM_D*TH_W-1:0]  af_d_o,
  output logic [NUM_D*TH_W-1:0]  ae_d_o,
  output logic [4:0]             state_o,
  output logic                   idle_out,
  output logic                   active_out,
  output logic [NUM_FIFOS-1:0]   error_out,
  output logic                   cfg_err_o,
  output logic [ERRCNT_W-1:0]    err_count_o
);
  localparam int CNT_W = $clog2(IDLE_DLY + 1);

  typedef enum logic [4:0] {
    S_RESET  = 5'b00001,
    S_INIT   = 5'b00010,
    S_IDLE   = 5'b00100,
    S_ACTIVE = 5'b01000,
    S_ERROR  = 5'b10000
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MF*TH_W-1:0] af_mf_q, af_mf_d, ae_mf_q, ae_mf_d;
  logic [NUM_VC*TH_W-1:0] af_vc_q, af_vc_d, ae_vc_q, ae_vc_d;
  logic [NUM_D*TH_W-1:0]  af_d_q, af_d_d, ae_d_q, ae_d_d;
  logic [NUM_FIFOS-1:0]   err_q, err_d;
  logic                   cfg_err_q, cfg_err_d;
  logic [ERRCNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]       empty_cnt_q, empty_cnt_d;
  logic                   init_prev_q;
  logic                   enter_err;
  logic                   fail_mf, fail_vc, fail_d, cfg_fail;

  fifo_th_chk #(.N(NUM_MF), .TH_W(TH_W)) u_chk_mf (.af(af_mf_i), .ae(ae_mf_i), .fail(fail_mf));
  fifo_th_chk #(.N(NUM_VC), .TH_W(TH_W)) u_chk_vc (.af(af_vc_i), .ae(ae_vc_i), .fail(fail_vc));
  fifo_th_chk #(.N(NUM_D),  .TH_W(TH_W)) u_chk_d  (.af(af_d_i),  .ae(ae_d_i),  .fail(fail_d));
  assign cfg_fail = fail_mf | fail_vc | fail_d;

  always_comb begin
    state_d     = state_q;
    af_mf_d     = af_mf_q;
    ae_mf_d     = ae_mf_q;
    af_vc_d     = af_vc_q;
    ae_vc_d     = ae_vc_q;
    af_d_d      = af_d_q;
    ae_d_d      = ae_d_q;
    err_d       = err_q;
    cfg_err_d   = cfg_err_q;
    err_cnt_d   = err_cnt_q;
    empty_cnt_d = '0;  // zero outside ACTIVE, so every ACTIVE entry starts fresh
    enter_err   = 1'b0;
    case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT: begin
        af_mf_d = af_mf_i;
        ae_mf_d = ae_mf_i;
        af_vc_d = af_vc_i;
        ae_vc_d = ae_vc_i;
        af_d_d  = af_d_i;
        ae_d_d  = ae_d_i;
        if (!init) begin
          if (cfg_fail) begin
            state_d   = S_ERROR;
            cfg_err_d = 1'b1;
            enter_err = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (|fifo_errors) begin
          state_d   = S_ERROR;
          err_d     = err_q | fifo_errors;
          enter_err = 1'b1;
        end else if (init) begin
          state_d = S_INIT;
        end else if (fifo_empties != '1) begin
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (|fifo_errors) begin
          state_d   = S_ERROR;
          err_d     = err_q | fifo_errors;
          enter_err = 1'b1;
        end else if (init) begin
          state_d = S_INIT;
        end else if (&fifo_empties) begin
          if (empty_cnt_q == CNT_W'(IDLE_DLY - 1)) state_d = S_IDLE;
          else empty_cnt_d = empty_cnt_q + CNT_W'(1);
        end
      end
      S_ERROR: begin
        // Only a 0->1 transition of init recovers; a level held across entry does not.
        if (init && !init_prev_q) begin
          state_d   = S_INIT;
          err_d     = '0;
          cfg_err_d = 1'b0;
        end else begin
          err_d = err_q | fifo_errors;
        end
      end
      default: state_d = S_RESET;
    endcase
    if (enter_err && err_cnt_q != '1) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RESET;
      af_mf_q     <= '0;
      ae_mf_q     <= '0;
      af_vc_q     <= '0;
      ae_vc_q     <= '0;
      af_d_q      <= '0;
      ae_d_q      <= '0;
      err_q       <= '0;
      cfg_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      empty_cnt_q <= '0;
      init_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      af_mf_q     <= af_mf_d;
      ae_mf_q     <= ae_mf_d;
      af_vc_q     <= af_vc_d;
      ae_vc_q     <= ae_vc_d;
      af_d_q      <= af_d_d;
      ae_d_q      <= ae_d_d;
      err_q       <= err_d;
      cfg_err_q   <= cfg_err_d;
      err_cnt_q   <= err_cnt_d;
      empty_cnt_q <= empty_cnt_d;
      init_prev_q <= init;
    end
  end

  assign state_o     = state_q;
  assign idle_out    = (state_q == S_IDLE);
  assign active_out  = (state_q == S_ACTIVE);
  assign error_out   = err_q;
  assign cfg_err_o   = cfg_err_q;
  assign err_count_o = err_cnt_q;
  assign af_mf_o     = af_mf_q;
  assign ae_mf_o     = ae_mf_q;
  assign af_vc_o     = af_vc_q;
  assign ae_vc_o     = ae_vc_q;
  assign af_d_o      = af_d_q;
  assign ae_d_o      = ae_d_q;
endmodule

// File: tb/tb_fifo_ctrl_fsm_param.sv
module tb_fifo_ctrl_fsm_param;
  localparam logic [4:0] RST = 5'b00001, INI = 5'b00010, IDL = 5'b00100,
                         ACT = 5'b01000, ERR = 5'b10000;

  logic       clk = 1'b0;
  logic       reset, init;
  logic [4:0] fifo_errors, fifo_empties;
  logic [1:0] af_mf_i, ae_mf_i, af_d_i, ae_d_i;
  logic [3:0] af_vc_i, ae_vc_i;
  logic [1:0] af_mf_o, ae_mf_o, af_d_o, ae_d_o;
  logic [3:0] af_vc_o, ae_vc_o;
  logic [4:0] state_o, error_out;
  logic       idle_out, active_out, cfg_err_o;
  logic [7:0] err_count_o;

  int n_chk = 0;
  int n_err = 0;

  fifo_ctrl_fsm_param dut (
    .clk(clk), .reset(reset), .init(init),
    .fifo_errors(fifo_errors), .fifo_empties(fifo_empties),
    .af_mf_i(af_mf_i), .ae_mf_i(ae_mf_i), .af_vc_i(af_vc_i), .ae_vc_i(ae_vc_i),
    .af_d_i(af_d_i), .ae_d_i(ae_d_i),
    .af_mf_o(af_mf_o), .ae_mf_o(ae_mf_o), .af_vc_o(af_vc_o), .ae_vc_o(ae_vc_o),
    .af_d_o(af_d_o), .ae_d_o(ae_d_o),
    .state_o(state_o), .idle_out(idle_out), .active_out(active_out),
    .error_out(error_out), .cfg_err_o(cfg_err_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; fifo_errors = '0; fifo_empties = '1;
    af_mf_i = '0; ae_mf_i = '0; af_vc_i = '0; ae_vc_i = '0; af_d_i = '0; ae_d_i = '0;
    tick(3);
    chk("rst_state", state_o, RST);
    chk("rst_thr", {af_mf_o, ae_mf_o, af_vc_o, ae_vc_o, af_d_o, ae_d_o}, 0);
    chk("rst_err", {error_out, cfg_err_o, idle_out, active_out}, 0);
    chk("rst_cnt", err_count_o, 0);

    // INIT with legal thresholds
    reset = 1'b0; init = 1'b1;
    af_vc_i = 4'hF; ae_vc_i = 4'h5; af_mf_i = 2'b11; ae_mf_i = 2'b01; af_d_i = 2'b11; ae_d_i = 2'b01;
    tick();
    chk("to_init", state_o, INI);
    tick(3);
    chk("init_hold", state_o, INI);
    init = 1'b0;
    tick();
    chk("to_idle", state_o, IDL);
    chk("idle_out", {idle_out, active_out}, 2'b10);
    chk("af_vc_o", af_vc_o, 4'hF);
    chk("ae_vc_o", ae_vc_o, 4'h5);
    chk("cfg_ok", cfg_err_o, 0);
    af_vc_i = 4'h0;
    tick();
    chk("thr_retained", {af_mf_o, ae_mf_o, af_vc_o, ae_vc_o, af_d_o, ae_d_o}, 16'hDF5D);
    af_vc_i = 4'hF;

    // Debounced ACTIVE -> IDLE
    fifo_empties = 5'b11110;
    tick();
    chk("to_active", {state_o, active_out, idle_out}, {ACT, 2'b10});
    fifo_empties = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("deb_act%0d", i), state_o, ACT);
    end
    tick();
    chk("deb_idle", state_o, IDL);

    // Glitch at count 2 restarts the count
    fifo_empties = 5'b11110; tick();
    fifo_empties = 5'b11111; tick(2);
    chk("glitch_pre", state_o, ACT);
    fifo_empties = 5'b11110; tick();
    fifo_empties = 5'b11111; tick(3);
    chk("glitch_act", state_o, ACT);
    tick();
    chk("glitch_idle", state_o, IDL);

    // Errors in ACTIVE
    fifo_empties = 5'b11110; tick();
    fifo_errors = 5'b00100; tick();
    chk("act_err_st", state_o, ERR);
    chk("act_err_eo", error_out, 5'b00100);
    chk("act_err_cnt", err_count_o, 1);
    fifo_errors = 5'b01000; tick();
    chk("err_accum", error_out, 5'b01100);
    fifo_errors = '0; fifo_empties = '1;

    // Recovery via init rising edge; errors ignored in INIT
    init = 1'b1; tick();
    chk("rec_state", state_o, INI);
    chk("rec_clr", {error_out, cfg_err_o}, 0);
    fifo_errors = 5'b11111; tick();
    chk("init_ign_err", {state_o, error_out}, {INI, 5'b00000});
    fifo_errors = '0; init = 1'b0; tick();
    chk("back_idle", state_o, IDL);

    // Error and init together in IDLE: error wins; held init does not recover
    fifo_errors = 5'b00001; init = 1'b1; tick();
    chk("err_wins", {state_o, error_out}, {ERR, 5'b00001});
    chk("err_cnt2", err_count_o, 2);
    fifo_errors = '0; tick(3);
    chk("held_init", state_o, ERR);
    init = 1'b0; tick();
    chk("init_low", state_o, ERR);
    init = 1'b1; tick();
    chk("rec2", {state_o, error_out}, {INI, 5'b00000});

    // Threshold consistency failure
    ae_mf_i = 2'b11; af_mf_i = 2'b10; init = 1'b0; tick();
    chk("cfg_state", state_o, ERR);
    chk("cfg_err", cfg_err_o, 1);
    chk("cfg_cnt", err_count_o, 3);
    chk("cfg_mf_o", {af_mf_o, ae_mf_o}, 4'b1011);

    // 258 more entries: counter saturates
    for (int i = 0; i < 258; i++) begin
      init = 1'b1; tick();
      init = 1'b0; tick();
      if (i == 0) chk("sat_first", err_count_o, 4);
    end
    chk("sat_state", state_o, ERR);
    chk("sat_cnt", err_count_o, 255);

    // Reset while in ERROR with error_out set
    fifo_errors = 5'b10010; tick();
    chk("err_pre_rst", error_out, 5'b10010);
    fifo_errors = '0; reset = 1'b1; tick();
    chk("mid_rst_st", state_o, RST);
    chk("mid_rst_out", {error_out, cfg_err_o, idle_out, active_out, err_count_o}, 0);
    chk("mid_rst_thr", {af_mf_o, ae_mf_o, af_vc_o, ae_vc_o, af_d_o, ae_d_o}, 0);
    reset = 1'b0; tick();
    chk("post_rst", state_o, INI);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
